// File: rtl/ewb_types.sv
// Shared types and constants for the L2 eviction write buffer.
package ewb_types;

    localparam int unsigned s_offset_default = 5;
    localparam int unsigned s_line_default   = 256;

    // Line-tag width for the default line geometry
    localparam int unsigned s_tag = 32 - s_offset_default;

    typedef logic [s_line_default-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        RESP
    } state_t;

    // Tag width for an arbitrary byte-offset width
    function automatic int unsigned tag_width(input int unsigned off);
        return 32 - off;
    endfunction

endpackage

// File: rtl/ewb_line_reg.sv
// Single buffered line: tag, data and valid flag, with a tag comparator.
module ewb_line_reg #(
    parameter int unsigned tag_w  = 27,
    parameter int unsigned line_w = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [tag_w-1:0]  load_tag,
    input  logic [line_w-1:0] load_data,
    input  logic [tag_w-1:0]  cmp_tag,
    output logic [tag_w-1:0]  tag,
    output logic [line_w-1:0] data,
    output logic              valid,
    output logic              hit
);

    // Load captures a new or coalesced line; clear only drops valid so the
    // drained line stays visible on the memory address/data outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag   <= '0;
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            tag   <= load_tag;
            data  <= load_data;
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

    assign hit = valid && (cmp_tag == tag);

endmodule

// File: rtl/l2_evict_buffer.sv
// Single-line eviction write buffer between the L2 and physical memory.
// Writebacks are absorbed in one handshake, drained after an idle period,
// and read hits on the buffered line are served without touching memory.
module l2_evict_buffer import ewb_types::*; #(
    parameter int unsigned s_offset    = s_offset_default,
    parameter int unsigned s_line      = s_line_default,
    parameter int unsigned DRAIN_DELAY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cache_read,
    input  logic              cache_write,
    input  logic [31:0]       cache_address,
    input  logic [s_line-1:0] cache_wdata,
    output logic              cache_resp,
    output logic [s_line-1:0] cache_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [s_line-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [s_line-1:0] pmem_rdata
);

    localparam int unsigned tag_w = tag_width(s_offset);
    localparam int unsigned cnt_w = (DRAIN_DELAY > 0) ? $clog2(DRAIN_DELAY + 1) : 1;

    state_t            state;
    logic [cnt_w-1:0]  idle_cnt;
    logic [s_line-1:0] rdata_q;

    logic [tag_w-1:0]  req_tag;
    logic [tag_w-1:0]  buf_tag;
    logic [s_line-1:0] buf_data;
    logic              buf_valid;
    logic              buf_hit;
    logic              buf_load;
    logic              buf_clear;
    logic              unused_offset;

    assign req_tag       = cache_address[31:s_offset];
    assign unused_offset = ^cache_address[s_offset-1:0];

    // A write is absorbed only when it cannot displace a different line
    assign buf_load  = (state == IDLE) && !cache_read && cache_write && (!buf_valid || buf_hit);
    assign buf_clear = (state == DRAIN) && pmem_resp;

    ewb_line_reg #(
        .tag_w  (tag_w),
        .line_w (s_line)
    ) u_line (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .clear     (buf_clear),
        .load_tag  (req_tag),
        .load_data (cache_wdata),
        .cmp_tag   (req_tag),
        .tag       (buf_tag),
        .data      (buf_data),
        .valid     (buf_valid),
        .hit       (buf_hit)
    );

    // Control FSM, idle counter and the L2 read-data register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idle_cnt <= '0;
            rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cache_read) begin
                        idle_cnt <= '0;
                        if (buf_hit) begin
                            rdata_q <= buf_data;
                            state   <= RESP;
                        end else begin
                            state <= READ;
                        end
                    end else if (cache_write) begin
                        idle_cnt <= '0;
                        // A miss on a full buffer drains first; the write stays
                        // pending and is accepted back in IDLE.
                        state    <= (buf_valid && !buf_hit) ? DRAIN : RESP;
                    end else if (buf_valid) begin
                        if (idle_cnt == cnt_w'(DRAIN_DELAY)) begin
                            idle_cnt <= '0;
                            state    <= DRAIN;
                        end else begin
                            idle_cnt <= idle_cnt + cnt_w'(1);
                        end
                    end else begin
                        idle_cnt <= '0;
                    end
                end
                READ: begin
                    if (pmem_resp) begin
                        rdata_q <= pmem_rdata;
                        state   <= RESP;
                    end
                end
                DRAIN: begin
                    if (pmem_resp) begin
                        state <= IDLE;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign cache_resp  = (state == RESP);
    assign cache_rdata = rdata_q;
    assign pmem_read   = (state == READ);
    assign pmem_write  = (state == DRAIN);
    assign pmem_wdata  = buf_data;

    // Outside READ the memory port shows the buffered line
    assign pmem_address = (state == READ) ? {req_tag, {s_offset{1'b0}}}
                                          : {buf_tag, {s_offset{1'b0}}};

endmodule
